// File: rtl/reservation_station_pkg.sv
// Shared constants, slot/operand types and the CDB operand-capture helper
// for the ALU/branch reservation station.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = 4;
    localparam int ROB_IDX_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [5:0] OP_BEQ  = 6'd1;
    localparam logic [5:0] OP_BNE  = 6'd2;
    localparam logic [5:0] OP_BLT  = 6'd3;
    localparam logic [5:0] OP_BGE  = 6'd4;
    localparam logic [5:0] OP_BLTU = 6'd5;
    localparam logic [5:0] OP_BGEU = 6'd6;
    localparam logic [5:0] OP_ADD  = 6'd16;
    localparam logic [5:0] OP_SUB  = 6'd17;
    localparam logic [5:0] OP_XOR  = 6'd18;
    localparam logic [5:0] OP_OR   = 6'd19;
    localparam logic [5:0] OP_AND  = 6'd20;
    localparam logic [5:0] OP_SLT  = 6'd21;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;   // producer ROB tag in the low bits while rdy=0
    } operand_t;

    typedef struct packed {
        logic [5:0]           op;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [31:0]          btb_pc;
        logic                 btb_predict;
    } slot_info_t;

    typedef struct packed {
        logic [5:0]           op;
        logic [31:0]          v1;
        logic [31:0]          v2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [31:0]          btb_pc;
        logic                 btb_predict;
        logic [ROB_IDX_W-1:0] rob_idx;
    } issue_t;

    // A pending operand snoops both CDBs; the ALU bus wins on a tie.
    function automatic operand_t capture(
        input operand_t             opnd,
        input logic                 alu_f,
        input logic [ROB_IDX_W-1:0] alu_tag,
        input logic [31:0]          alu_val,
        input logic                 lsb_f,
        input logic [ROB_IDX_W-1:0] lsb_tag,
        input logic [31:0]          lsb_val
    );
        operand_t res;
        res = opnd;
        if (!opnd.rdy) begin
            if (alu_f && alu_tag == opnd.val[ROB_IDX_W-1:0]) begin
                res.rdy = 1'b1;
                res.val = alu_val;
            end else if (lsb_f && lsb_tag == opnd.val[ROB_IDX_W-1:0]) begin
                res.rdy = 1'b1;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_rs_priority_sel.sv
// Lowest-set-bit encoder returning {found, index}; used for free-slot
// lookup and for issue selection.
module rs_priority_sel #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: tag-tracked operand wakeup from two CDBs,
// lowest-index issue, flush on mispredict. Optional: RS_WAKEUP_BYPASS_EN.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 Dis_flag,
    input  logic [RS_IDX_W-1:0]  Dis_put_idx,
    input  logic [5:0]           Dis_op,
    input  logic [31:0]          Dis_imm,
    input  logic [31:0]          Dis_PC,
    input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
    input  logic                 Dis_R1,
    input  logic                 Dis_R2,
    input  logic [31:0]          Dis_V1,
    input  logic [31:0]          Dis_V2,
    input  logic [31:0]          Dis_BTB_PC,
    input  logic                 Dis_BTB_predict,
    input  logic                 ALU_CDB_flag,
    input  logic [ROB_IDX_W-1:0] ALU_CDB_idx,
    input  logic [31:0]          ALU_CDB_val,
    input  logic                 LSB_CDB_flag,
    input  logic [ROB_IDX_W-1:0] LSB_CDB_idx,
    input  logic [31:0]          LSB_CDB_val,
    output logic [RS_IDX_W-1:0]  free_idx,
    output logic                 rs_full,
    output logic                 ALU_flag,
    output logic [5:0]           ALU_op,
    output logic [31:0]          ALU_V1,
    output logic [31:0]          ALU_V2,
    output logic [31:0]          ALU_imm,
    output logic [31:0]          ALU_PC,
    output logic [31:0]          ALU_BTB_PC,
    output logic                 ALU_BTB_predict,
    output logic [ROB_IDX_W-1:0] ALU_ROB_idx
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    slot_info_t         info_q [RS_SIZE];
    operand_t           op1_q  [RS_SIZE];
    operand_t           op2_q  [RS_SIZE];
    operand_t           op1_w  [RS_SIZE];
    operand_t           op2_w  [RS_SIZE];
    operand_t           dis_op1, dis_op2;
    logic [RS_SIZE-1:0] ready;

    logic                alu_flag_q;
    issue_t              alu_q;
    logic                free_found, issue_found;
    logic [RS_IDX_W-1:0] free_sel, issue_idx;
    logic [RS_IDX_W:0]   free_cnt;
    logic                active, dis_we, issue_en;

    assign active   = rdy_in && !clear_in;
    assign dis_we   = active && Dis_flag && !busy_q[Dis_put_idx];
    assign issue_en = active && issue_found;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_w[i] = capture(op1_q[i], ALU_CDB_flag, ALU_CDB_idx, ALU_CDB_val,
                               LSB_CDB_flag, LSB_CDB_idx, LSB_CDB_val);
            op2_w[i] = capture(op2_q[i], ALU_CDB_flag, ALU_CDB_idx, ALU_CDB_val,
                               LSB_CDB_flag, LSB_CDB_idx, LSB_CDB_val);
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = busy_q[i] && op1_w[i].rdy && op2_w[i].rdy;
`else
            ready[i] = busy_q[i] && op1_q[i].rdy && op2_q[i].rdy;
`endif
        end
        dis_op1 = capture('{rdy: Dis_R1, val: Dis_V1}, ALU_CDB_flag, ALU_CDB_idx, ALU_CDB_val,
                          LSB_CDB_flag, LSB_CDB_idx, LSB_CDB_val);
        dis_op2 = capture('{rdy: Dis_R2, val: Dis_V2}, ALU_CDB_flag, ALU_CDB_idx, ALU_CDB_val,
                          LSB_CDB_flag, LSB_CDB_idx, LSB_CDB_val);
    end

    rs_priority_sel #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_sel)
    );

    rs_priority_sel #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_sel (
        .req_i   (ready),
        .found_o (issue_found),
        .idx_o   (issue_idx)
    );

    // Full one slot early so a dispatch already in flight still lands.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + {{RS_IDX_W{1'b0}}, ~busy_q[i]};
        end
    end

    assign free_idx = free_found ? free_sel : '0;
    assign rs_full  = free_cnt <= (RS_IDX_W + 1)'(1);

    always_comb begin
        busy_d = busy_q;
        if (rdy_in && clear_in) begin
            busy_d = '0;
        end else begin
            if (issue_en) busy_d[issue_idx]  = 1'b0;
            if (dis_we)   busy_d[Dis_put_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // NOTE: slot payload is qualified by busy_q, so this storage needs no reset.
    always_ff @(posedge clk_in) begin
        if (active) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (dis_we && Dis_put_idx == RS_IDX_W'(i)) begin
                    info_q[i] <= '{op: Dis_op, imm: Dis_imm, pc: Dis_PC, rob_idx: Dis_ROB_idx,
                                   btb_pc: Dis_BTB_PC, btb_predict: Dis_BTB_predict};
                    op1_q[i]  <= dis_op1;
                    op2_q[i]  <= dis_op2;
                end else begin
                    op1_q[i]  <= op1_w[i];
                    op2_q[i]  <= op2_w[i];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            alu_flag_q <= 1'b0;
            alu_q      <= '0;
        end else begin
            alu_flag_q <= issue_en;
            if (issue_en) begin
                alu_q <= '{op: info_q[issue_idx].op,
                           v1: op1_w[issue_idx].val,
                           v2: op2_w[issue_idx].val,
                           imm: info_q[issue_idx].imm,
                           pc: info_q[issue_idx].pc,
                           btb_pc: info_q[issue_idx].btb_pc,
                           btb_predict: info_q[issue_idx].btb_predict,
                           rob_idx: info_q[issue_idx].rob_idx};
            end
        end
    end

    assign ALU_flag        = alu_flag_q;
    assign ALU_op          = alu_q.op;
    assign ALU_V1          = alu_q.v1;
    assign ALU_V2          = alu_q.v2;
    assign ALU_imm         = alu_q.imm;
    assign ALU_PC          = alu_q.pc;
    assign ALU_BTB_PC      = alu_q.btb_pc;
    assign ALU_BTB_predict = alu_q.btb_predict;
    assign ALU_ROB_idx     = alu_q.rob_idx;

    dispatch_into_free_slot: assert property (
        @(posedge clk_in) disable iff (!rst_n)
        (rdy_in && !clear_in && Dis_flag) |-> !busy_q[Dis_put_idx]
    ) else $error("dispatch into busy RS slot %0d", Dis_put_idx);

endmodule
